// File: rtl/range_stepper_pkg.sv
// Shared types and constants for the range_stepper operand stepper.
// Optional RANGE_STEPPER_ACCEL_EN constants live here as well.
package range_stepper_pkg;

    typedef enum logic {
        TRACK,
        ACTIVE
    } state_e;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DN
    } dir_e;

    localparam int ACCEL_THRESHOLD = 8;
    localparam int ACCEL_DIV       = 4;

    // Fast repeat period, never below one cycle.
    function automatic int accel_period(input int rep);
        return (rep / ACCEL_DIV < 1) ? 1 : rep / ACCEL_DIV;
    endfunction

endpackage

// File: rtl/range_stepper_key_debounce.sv
// key_debounce: 2-FF synchronizer plus stable-count debouncer.
// level is the debounced raw level (1 = released), press marks 1->0.
module key_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          press_q;

    // Synchronize, then accept a new level after DEB_CYCLES stable cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n};
            press_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                cnt_q   <= '0;
                level_q <= sync_q[1];
                press_q <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/range_stepper.sv
// range_stepper: key-driven base+offset stepper with auto-repeat and go/done.
// Define RANGE_STEPPER_ACCEL_EN to enable the fast repeat after a long hold.
module range_stepper
    import range_stepper_pkg::*;
#(
    parameter int WIDTH         = 12,
    parameter int SPAN          = 256,
    parameter int DEB_CYCLES    = 1000000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 3145728,
    localparam int OW           = $clog2(SPAN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_up_n,
    input  logic             key_dn_n,
    input  logic             key_load_n,
    input  logic [WIDTH-1:0] base,
    output logic [WIDTH-1:0] value,
    output logic [OW-1:0]    offset,
    output logic             at_min,
    output logic             at_max,
    output logic             step_pulse,
    output logic             go,
    input  logic             done
);
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [OW-1:0] OFF_MAX = OW'(SPAN - 1);

    logic up_lvl, up_prs, dn_lvl, dn_prs, ld_lvl, ld_prs;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up (
        .clk(clk), .reset(reset), .key_n(key_up_n), .level(up_lvl), .press(up_prs)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dn (
        .clk(clk), .reset(reset), .key_n(key_dn_n), .level(dn_lvl), .press(dn_prs)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ld (
        .clk(clk), .reset(reset), .key_n(key_load_n), .level(ld_lvl), .press(ld_prs)
    );

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  base_q, base_d, value_q, value_d;
    logic [OW-1:0]     off_q, off_d;
    logic [TW-1:0]     tmr_q, tmr_d, limit, period;
    logic              rep_q, rep_d;
    logic              go_q, go_d, pend_q, pend_d;
    logic              min_q, max_q, stp_q, stp;
    logic              fire, restart, sat;
    dir_e              hold_dir, dir;

`ifdef RANGE_STEPPER_ACCEL_EN
    localparam int FAST = accel_period(REPEAT_CYCLES);
    logic [3:0] acc_q, acc_d;

    // Count timer-driven steps of the current hold; switch to the fast period.
    always_comb begin
        acc_d = acc_q;
        if (restart || sat) begin
            acc_d = '0;
        end else if (fire && acc_q < 4'(ACCEL_THRESHOLD)) begin
            acc_d = acc_q + 4'd1;
        end
        period = (acc_q >= 4'(ACCEL_THRESHOLD)) ? TW'(FAST) : TW'(REPEAT_CYCLES);
    end

    // Acceleration counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    assign period = TW'(REPEAT_CYCLES);
`endif

    // Next-state: hold timer, step decision, load, bounds and go/done.
    always_comb begin
        state_d  = state_q;
        base_d   = (state_q == TRACK) ? base : base_q;
        off_d    = off_q;
        tmr_d    = tmr_q;
        rep_d    = rep_q;
        go_d     = go_q;
        pend_d   = pend_q;
        stp      = 1'b0;
        fire     = 1'b0;
        restart  = 1'b0;
        dir      = DIR_NONE;
        hold_dir = DIR_NONE;
        if (!up_lvl && dn_lvl) hold_dir = DIR_UP;
        if (!dn_lvl && up_lvl) hold_dir = DIR_DN;
        limit = rep_q ? period : TW'(HOLD_CYCLES);

        if (hold_dir == DIR_NONE) begin
            tmr_d   = '0;
            rep_d   = 1'b0;
            restart = 1'b1;
        end else if ((up_prs && hold_dir == DIR_UP) ||
                     (dn_prs && hold_dir == DIR_DN)) begin
            dir     = hold_dir;
            tmr_d   = '0;
            rep_d   = 1'b0;
            restart = 1'b1;
        end else if (tmr_q == limit - TW'(1)) begin
            dir   = hold_dir;
            fire  = 1'b1;
            tmr_d = '0;
            rep_d = 1'b1;
        end else begin
            tmr_d = tmr_q + TW'(1);
        end

        if (ld_prs) begin
            dir     = DIR_NONE;
            fire    = 1'b0;
            restart = 1'b1;
            tmr_d   = '0;
            rep_d   = 1'b0;
            off_d   = '0;
            state_d = TRACK;
        end

        unique case (dir)
            DIR_UP: if (off_q != OFF_MAX) begin
                off_d = off_q + OW'(1);
                stp   = 1'b1;
            end
            DIR_DN: if (off_q != '0) begin
                off_d = off_q - OW'(1);
                stp   = 1'b1;
            end
            default: ;
        endcase
        sat = (dir != DIR_NONE) && !stp;

        if (stp) state_d = ACTIVE;

        if (go_q) begin
            if (done) go_d = 1'b0;
            if (stp) pend_d = 1'b1;
        end else if (pend_q || stp) begin
            go_d   = 1'b1;
            pend_d = 1'b0;
        end

        value_d = base_d + WIDTH'(off_d);
    end

    // State, operand and handshake registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TRACK;
            base_q  <= '0;
            value_q <= '0;
            off_q   <= '0;
            tmr_q   <= '0;
            rep_q   <= 1'b0;
            go_q    <= 1'b0;
            pend_q  <= 1'b0;
            min_q   <= 1'b1;
            max_q   <= 1'b0;
            stp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            value_q <= value_d;
            off_q   <= off_d;
            tmr_q   <= tmr_d;
            rep_q   <= rep_d;
            go_q    <= go_d;
            pend_q  <= pend_d;
            min_q   <= (off_d == '0);
            max_q   <= (off_d == OFF_MAX);
            stp_q   <= stp;
        end
    end

    assign value      = value_q;
    assign offset     = off_q;
    assign at_min     = min_q;
    assign at_max     = max_q;
    assign step_pulse = stp_q;
    assign go         = go_q;

endmodule

// File: tb/tb_range_stepper.sv
// Directed bench for range_stepper with small timing parameters.
// Build with RANGE_STEPPER_ACCEL_EN to check the fast repeat period.
module tb_range_stepper;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_up_n, key_dn_n, key_load_n, done;
    logic [11:0] base, value;
    logic [3:0]  offset;
    logic        at_min, at_max, step_pulse, go;

    int nvec   = 0;
    int nerr   = 0;
    int cyc    = 0;
    int npulse = 0;

`ifdef RANGE_STEPPER_ACCEL_EN
    localparam int FAST_GAP = 2;
`else
    localparam int FAST_GAP = 8;
`endif

    range_stepper #(
        .WIDTH(12), .SPAN(16), .DEB_CYCLES(4),
        .HOLD_CYCLES(20), .REPEAT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .key_up_n(key_up_n), .key_dn_n(key_dn_n), .key_load_n(key_load_n),
        .base(base), .value(value), .offset(offset),
        .at_min(at_min), .at_max(at_max), .step_pulse(step_pulse),
        .go(go), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
        if (step_pulse) npulse++;
    endtask

    task automatic wait_pulse(input int maxc, output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (step_pulse) begin
                ok = 1'b1;
                at = cyc;
                return;
            end
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        key_up_n   = 1'b1;
        key_dn_n   = 1'b1;
        key_load_n = 1'b1;
        done       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        npulse = 0;
    endtask

    task automatic test_reset();
        base       = 12'h0A0;
        key_up_n   = 1'b1;
        key_dn_n   = 1'b1;
        key_load_n = 1'b1;
        done       = 1'b0;
        reset      = 1'b1;
        #2;
        nvec++;
        if ({value, offset, at_min, at_max, step_pulse, go} !== {12'h000, 4'h0, 4'b1000}) begin
            nerr++;
            $display("FAIL reset_state: got v=%h o=%h min=%b max=%b sp=%b go=%b want 000/0/1/0/0/0",
                     value, offset, at_min, at_max, step_pulse, go);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        nvec++;
        if (value !== 12'h0A0 || offset !== 4'h0 || at_min !== 1'b1) begin
            nerr++;
            $display("FAIL track_base: got v=%h o=%h min=%b want 0a0/0/1", value, offset, at_min);
        end
        base = 12'h0B0;
        tick();
        nvec++;
        if (value !== 12'h0B0) begin
            nerr++;
            $display("FAIL track_follow: got %h want 0b0", value);
        end
        nvec++;
        if (go !== 1'b0) begin
            nerr++;
            $display("FAIL track_no_go: got %b want 0", go);
        end
    endtask

    task automatic test_tap();
        do_reset();
        base = 12'h0A0;
        tick();
        npulse = 0;
        key_up_n = 1'b0;
        repeat (10) tick();
        key_up_n = 1'b1;
        repeat (20) tick();
        nvec++;
        if (npulse !== 1) begin
            nerr++;
            $display("FAIL tap_pulses: got %0d want 1", npulse);
        end
        nvec++;
        if (value !== 12'h0A1 || offset !== 4'h1 || at_min !== 1'b0) begin
            nerr++;
            $display("FAIL tap_value: got v=%h o=%h min=%b want 0a1/1/0", value, offset, at_min);
        end
        nvec++;
        if (go !== 1'b1) begin
            nerr++;
            $display("FAIL tap_go_held: got %b want 1", go);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        nvec++;
        if (go !== 1'b0) begin
            nerr++;
            $display("FAIL tap_go_drop: got %b want 0", go);
        end
        base = 12'h000;
        tick();
        tick();
        nvec++;
        if (value !== 12'h0A1) begin
            nerr++;
            $display("FAIL active_freeze: got %h want 0a1", value);
        end
    endtask

    task automatic test_hold_sat();
        bit ok, allok;
        int t0, t1, t2, t;
        do_reset();
        base = 12'h0A0;
        done = 1'b1;
        tick();
        key_up_n = 1'b0;
        wait_pulse(20, ok, t0);
        nvec++;
        if (!ok || offset !== 4'h1) begin
            nerr++;
            $display("FAIL hold_first: got ok=%b o=%h want 1/1", ok, offset);
        end
        wait_pulse(40, ok, t1);
        nvec++;
        if (!ok || t1 - t0 !== 20) begin
            nerr++;
            $display("FAIL hold_delay: got ok=%b gap=%0d want 1/20", ok, t1 - t0);
        end
        wait_pulse(20, ok, t2);
        nvec++;
        if (!ok || t2 - t1 !== 8) begin
            nerr++;
            $display("FAIL repeat_gap: got ok=%b gap=%0d want 1/8", ok, t2 - t1);
        end
        allok = 1'b1;
        repeat (12) begin
            wait_pulse(20, ok, t);
            allok &= ok;
        end
        nvec++;
        if (!allok || offset !== 4'hF || value !== 12'h0AF || at_max !== 1'b1) begin
            nerr++;
            $display("FAIL saturate: got ok=%b o=%h v=%h max=%b want 1/f/0af/1",
                     allok, offset, value, at_max);
        end
        npulse = 0;
        repeat (40) tick();
        nvec++;
        if (npulse !== 0 || offset !== 4'hF) begin
            nerr++;
            $display("FAIL sat_quiet: got pulses=%0d o=%h want 0/f", npulse, offset);
        end
        key_up_n = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_back_to_back();
        int gohi;
        do_reset();
        base = 12'h0A0;
        done = 1'b0;
        tick();
        npulse = 0;
        repeat (2) begin
            key_up_n = 1'b0;
            repeat (10) tick();
            key_up_n = 1'b1;
            repeat (10) tick();
        end
        nvec++;
        if (npulse !== 2 || offset !== 4'h2 || go !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_steps: got pulses=%0d o=%h go=%b want 2/2/1", npulse, offset, go);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        nvec++;
        if (go !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_drop: got %b want 0", go);
        end
        tick();
        nvec++;
        if (go !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_reassert: got %b want 1", go);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        gohi = 0;
        repeat (10) begin
            if (go) gohi++;
            tick();
        end
        nvec++;
        if (gohi !== 0) begin
            nerr++;
            $display("FAIL b2b_no_third: got %0d go cycles want 0", gohi);
        end
    endtask

    task automatic test_both_keys();
        bit ok;
        int rel, t;
        do_reset();
        base = 12'h0A0;
        done = 1'b1;
        tick();
        npulse = 0;
        key_up_n = 1'b0;
        key_dn_n = 1'b0;
        repeat (40) tick();
        nvec++;
        if (npulse !== 0 || offset !== 4'h0) begin
            nerr++;
            $display("FAIL both_held: got pulses=%0d o=%h want 0/0", npulse, offset);
        end
        key_dn_n = 1'b1;
        rel = cyc;
        wait_pulse(40, ok, t);
        nvec++;
        if (!ok || t - rel !== 26 || offset !== 4'h1) begin
            nerr++;
            $display("FAIL both_release: got ok=%b dt=%0d o=%h want 1/26/1", ok, t - rel, offset);
        end
        key_up_n = 1'b1;
        repeat (15) tick();
        key_load_n = 1'b0;
        repeat (10) tick();
        key_load_n = 1'b1;
        repeat (10) tick();
        nvec++;
        if (offset !== 4'h0 || at_min !== 1'b1 || value !== 12'h0A0) begin
            nerr++;
            $display("FAIL load: got o=%h min=%b v=%h want 0/1/0a0", offset, at_min, value);
        end
        base = 12'h123;
        tick();
        nvec++;
        if (value !== 12'h123) begin
            nerr++;
            $display("FAIL load_track: got %h want 123", value);
        end
    endtask

    task automatic test_accel_and_reset();
        bit ok, allok;
        int p [10];
        do_reset();
        base = 12'h100;
        done = 1'b1;
        tick();
        key_up_n = 1'b0;
        repeat (160) tick();
        key_up_n = 1'b1;
        repeat (20) tick();
        nvec++;
        if (offset !== 4'hF) begin
            nerr++;
            $display("FAIL accel_setup: got o=%h want f", offset);
        end
        done = 1'b0;
        key_dn_n = 1'b0;
        allok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_pulse(40, ok, p[i]);
            allok &= ok;
        end
        nvec++;
        if (!allok || p[1] - p[0] !== 20 || p[8] - p[7] !== 8) begin
            nerr++;
            $display("FAIL dn_repeat: got ok=%b g1=%0d g8=%0d want 1/20/8",
                     allok, p[1] - p[0], p[8] - p[7]);
        end
        nvec++;
        if (p[9] - p[8] !== FAST_GAP || offset !== 4'h5 || value !== 12'h105) begin
            nerr++;
            $display("FAIL fast_gap: got gap=%0d o=%h v=%h want %0d/5/105",
                     p[9] - p[8], offset, value, FAST_GAP);
        end
        nvec++;
        if (go !== 1'b1) begin
            nerr++;
            $display("FAIL pre_reset_go: got %b want 1", go);
        end
        reset = 1'b1;
        #1;
        nvec++;
        if (go !== 1'b0 || offset !== 4'h0 || value !== 12'h000 || at_min !== 1'b1) begin
            nerr++;
            $display("FAIL async_reset: got go=%b o=%h v=%h min=%b want 0/0/000/1",
                     go, offset, value, at_min);
        end
        key_dn_n = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        key_up_n   = 1'b1;
        key_dn_n   = 1'b1;
        key_load_n = 1'b1;
        done       = 1'b0;
        base       = '0;
        #1;
        test_reset();
        test_tap();
        test_hold_sat();
        test_back_to_back();
        test_both_keys();
        test_accel_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
